led_pwm_dimmer: RTL and testbench
=================================

Name: led_pwm_dimmer

Overview:
- Output stage directly downstream of the LED pattern generators (led_kitt, svn_seg_cntr); sits between the board-level LED driver and the pads.
- Takes a logical active-high LED pattern and gates it with a 15-slot PWM brightness waveform.
- Brightness level 0..15 is either stepped manually by a debounced push-button or swept automatically in "breathe" mode.
- Applies board LED polarity at the output.

Parameters:
- CLK_IN_MHZ, 100, system clock frequency in MHz.
- LED_POLARITY, 1'b1, active level of led_o (1 = active-high LEDs).
- BTN_POLARITY, 1'b0, pressed level of btn_i.
- WIDTH, 8, number of LED lines.
- PWM_KHZ, 1, PWM frame rate in kHz.
- DEBOUNCE_MS, 20, required button stable time in ms.
- FADE_STEP_MS, 32, breathe-mode time per level step in ms.

Ports:
- clk_i  input  1  system clock.
- rstn_i  input  1  reset; synchronous, active-low.
- pattern_i  input  WIDTH  logical LED pattern; 1 = LED on; synchronous to clk_i.
- btn_i  input  1  raw asynchronous push-button.
- mode_i  input  1  0 = manual, 1 = breathe; asynchronous and quasi-static.
- led_o  output  WIDTH  dimmed, polarity-applied LED drive.
- level_o  output  4  current brightness level (debug).

Behaviour:
- Derived constants, integer division, each clamped to a minimum of 1:
  - SLOT_CYC = CLK_IN_MHZ*1000/(PWM_KHZ*15)
  - DB_CYC = CLK_IN_MHZ*1000*DEBOUNCE_MS
  - FADE_CYC = CLK_IN_MHZ*1000*FADE_STEP_MS
  - Counter widths are sized with $clog2 of each constant.
- Reset (rstn_i = 0 at a clk_i edge) sets, at that edge:
  - level = 15
  - state = MANUAL
  - slot_cnt = 0, all prescale counters = 0
  - debounced button = released
  - led_o = {WIDTH{~LED_POLARITY}} (all off)
  - level_o = 15
- Reset mid-operation aborts any ramp, debounce or PWM frame immediately.
- Synchronisers:
  - btn_i and mode_i each pass through a 2-flop synchroniser.
  - btn_i is normalised so that 1 = pressed, using BTN_POLARITY.
- Debounce:
  - A counter increments while the synchronised button differs from the debounced state; it clears whenever they match.
  - When the count reaches DB_CYC-1, the debounced state takes the new value.
  - press_pulse is a one-cycle pulse on the debounced 0->1 transition only. No pulse on release.
  - Glitches shorter than DB_CYC cycles are ignored.
- PWM:
  - The slot prescaler counts 0..SLOT_CYC-1; on wrap, slot_cnt advances 0..14 and then wraps to 0.
  - pwm_on = (slot_cnt < level).
  - level 0 gives always off; level 15 gives always on (no gap); duty = level/15.
- Output:
  - led_o[i] = LED_POLARITY ? (pattern_i[i] & pwm_on) : ~(pattern_i[i] & pwm_on).
  - Registered: exactly 1 cycle latency from pattern_i and pwm_on to led_o.
  - level_o is driven directly from the level register.
- FSM, states MANUAL, UP, DOWN; m = synchronised mode_i:
  - MANUAL:
    - On press_pulse: level increments by 1; 15 wraps to 0.
    - m = 1: go to UP and clear the fade counter. level keeps its current value.
  - UP:
    - The fade counter counts 0..FADE_CYC-1; on wrap (fade_tick), level increments.
    - On a fade_tick when level = 14: level becomes 15 and the state goes to DOWN.
    - If UP is entered with level = 15: the next fade_tick goes to DOWN with level held at 15.
  - DOWN:
    - On fade_tick, level decrements.
    - On a fade_tick when level = 1: level becomes 0 and the state goes to UP.
  - UP/DOWN with m = 0: go to MANUAL; level holds its value; fade counter clears.
  - press_pulse is ignored in UP and DOWN.
  - press_pulse in the same cycle as MANUAL->UP (m = 1): the transition wins and the press is discarded.
- Level changes take effect at the next slot comparison. No frame realignment: slot_cnt is never reset except by rstn_i.

Test Plan:
1. Reset, CLK_IN_MHZ=1, PWM_KHZ=1 (SLOT_CYC=66), LED_POLARITY=1, pattern_i=8'hA5, mode_i=0, no button -> during reset led_o=8'h00; 1 cycle after pattern is sampled, led_o=8'hA5 constant; level_o=15.
2. Same config, one debounced press (btn held 2*DB_CYC) -> level_o wraps 15->0; thereafter led_o=8'h00 constant. Second press -> level 1; led_o=8'hA5 for 66 of every 990 cycles.
3. btn_i glitch of DB_CYC-2 cycles, then a bounce train ending in a 2*DB_CYC hold -> exactly one level increment, on the debounced edge; no increment on release.
4. mode_i=1 from level 13, FADE_STEP_MS=1 (FADE_CYC=1000):
   - level_o sequence 13,14,15,14,...,1,0,1, one step per 1000 cycles after the 2-cycle sync delay.
   - Button presses during the ramp have no effect.
5. mode_i 1->0 while level_o=9 in DOWN -> level_o holds 9. A press on the same cycle that mode_i goes 0->1 is discarded (level unchanged, state UP).
6. LED_POLARITY=0, level 15, pattern_i=8'h0F -> led_o=8'hF0. Assert rstn_i low for one cycle mid-ramp -> next edge led_o=8'hFF, level_o=15, state MANUAL.

Source files
------------

// File: rtl/led_pwm_dimmer.sv
// LED output stage: gates a logical pattern with a 15-slot PWM waveform whose
// level is stepped by a debounced button or swept up/down in breathe mode.
module led_pwm_dimmer #(
  parameter int   CLK_IN_MHZ   = 100,
  parameter logic LED_POLARITY = 1'b1,
  parameter logic BTN_POLARITY = 1'b0,
  parameter int   WIDTH        = 8,
  parameter int   PWM_KHZ      = 1,
  parameter int   DEBOUNCE_MS  = 20,
  parameter int   FADE_STEP_MS = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [WIDTH-1:0] pattern_i,
  input  logic             btn_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] led_o,
  output logic [3:0]       level_o
);

  localparam int SLOT_RAW = CLK_IN_MHZ * 1000 / (PWM_KHZ * 15);
  localparam int DB_RAW   = CLK_IN_MHZ * 1000 * DEBOUNCE_MS;
  localparam int FADE_RAW = CLK_IN_MHZ * 1000 * FADE_STEP_MS;
  localparam int SLOT_CYC = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
  localparam int DB_CYC   = (DB_RAW < 1) ? 1 : DB_RAW;
  localparam int FADE_CYC = (FADE_RAW < 1) ? 1 : FADE_RAW;
  localparam int SW = (SLOT_CYC > 1) ? $clog2(SLOT_CYC) : 1;
  localparam int DW = (DB_CYC > 1) ? $clog2(DB_CYC) : 1;
  localparam int FW = (FADE_CYC > 1) ? $clog2(FADE_CYC) : 1;

  typedef enum logic [1:0] {MANUAL, UP, DOWN} state_t;

  logic [1:0] btn_sync, mode_sync;
  logic       pressed, m;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      btn_sync  <= {2{~BTN_POLARITY}};
      mode_sync <= 2'b00;
    end else begin
      btn_sync  <= {btn_sync[0], btn_i};
      mode_sync <= {mode_sync[0], mode_i};
    end
  end

  assign pressed = (btn_sync[1] == BTN_POLARITY);
  assign m       = mode_sync[1];

  // Debounce: state follows the input only after DB_CYC consecutive differing cycles.
  logic          db_state, db_done, press_pulse;
  logic [DW-1:0] db_cnt;

  assign db_done     = (db_cnt == DW'(DB_CYC - 1));
  assign press_pulse = pressed & ~db_state & db_done;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      db_state <= 1'b0;
      db_cnt   <= '0;
    end else if (pressed != db_state) begin
      if (db_done) begin
        db_state <= pressed;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end else begin
      db_cnt <= '0;
    end
  end

  logic [SW-1:0] pre_cnt;
  logic [3:0]    slot_cnt;
  logic          slot_wrap;

  assign slot_wrap = (pre_cnt == SW'(SLOT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pre_cnt  <= '0;
      slot_cnt <= 4'd0;
    end else if (slot_wrap) begin
      pre_cnt  <= '0;
      slot_cnt <= (slot_cnt == 4'd14) ? 4'd0 : slot_cnt + 4'd1;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
    end
  end

  state_t        state, state_n;
  logic [3:0]    level, level_n;
  logic [FW-1:0] fade_cnt, fade_n;
  logic          fade_tick, pwm_on;

  assign fade_tick = (fade_cnt == FW'(FADE_CYC - 1));
  assign pwm_on    = (slot_cnt < level);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= MANUAL;
      level    <= 4'd15;
      fade_cnt <= '0;
    end else begin
      state    <= state_n;
      level    <= level_n;
      fade_cnt <= fade_n;
    end
  end

  always_comb begin
    state_n = state;
    level_n = level;
    fade_n  = fade_cnt;
    case (state)
      MANUAL: begin
        fade_n = '0;
        // Entering breathe takes priority over a coincident press.
        if (m)                state_n = UP;
        else if (press_pulse) level_n = level + 4'd1;
      end
      UP, DOWN: begin
        if (!m) begin
          state_n = MANUAL;
          fade_n  = '0;
        end else begin
          fade_n = fade_tick ? '0 : fade_cnt + 1'b1;
          if (fade_tick) begin
            if (state == UP) begin
              if (level >= 4'd14) begin
                level_n = 4'd15;
                state_n = DOWN;
              end else begin
                level_n = level + 4'd1;
              end
            end else if (level <= 4'd1) begin
              level_n = 4'd0;
              state_n = UP;
            end else begin
              level_n = level - 4'd1;
            end
          end
        end
      end
      default: state_n = MANUAL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i)           led_o <= {WIDTH{~LED_POLARITY}};
    else if (LED_POLARITY) led_o <= pattern_i & {WIDTH{pwm_on}};
    else                   led_o <= ~(pattern_i & {WIDTH{pwm_on}});
  end

  assign level_o = level;

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Randomised bench for led_pwm_dimmer: a timeline reference model pushes the
// expected outputs per edge; a negedge monitor pops and compares.
module tb_led_pwm_dimmer;
  localparam int W    = 8;
  localparam int SLOT = 66;
  localparam int DB   = 1000;
  localparam int FADE = 1000;

  logic         clk = 1'b0, rstn = 1'b0, btn = 1'b1, mode = 1'b0;
  logic [W-1:0] pattern = 8'hA5;
  logic [W-1:0] led_p, led_n;
  logic [3:0]   lvl_p, lvl_n;

  always #5 clk = ~clk;

  led_pwm_dimmer #(.CLK_IN_MHZ(1), .LED_POLARITY(1'b1), .BTN_POLARITY(1'b0), .WIDTH(W),
                   .PWM_KHZ(1), .DEBOUNCE_MS(1), .FADE_STEP_MS(1)) dut_p (
    .clk_i(clk), .rstn_i(rstn), .pattern_i(pattern), .btn_i(btn), .mode_i(mode),
    .led_o(led_p), .level_o(lvl_p));

  led_pwm_dimmer #(.CLK_IN_MHZ(1), .LED_POLARITY(1'b0), .BTN_POLARITY(1'b0), .WIDTH(W),
                   .PWM_KHZ(1), .DEBOUNCE_MS(1), .FADE_STEP_MS(1)) dut_n (
    .clk_i(clk), .rstn_i(rstn), .pattern_i(pattern), .btn_i(btn), .mode_i(mode),
    .led_o(led_n), .level_o(lvl_n));

  typedef struct packed {
    logic [W-1:0] lp;
    logic [W-1:0] ln;
    logic [3:0]   lv;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;

  // Reference model: elapsed-time arithmetic for PWM and fade, run lengths for debounce.
  int cyc, dbrun, fcnt, lvl;
  bit b_d1, b_d2, m_d1, m_d2, db, breathe, going_up;

  always @(posedge clk) begin
    exp_t e;
    bit   p, mm, pulse, on;
    if (!rstn) begin
      cyc = 0; dbrun = 0; fcnt = 0; lvl = 15;
      b_d1 = 0; b_d2 = 0; m_d1 = 0; m_d2 = 0;
      db = 0; breathe = 0; going_up = 1;
      e.lp = '0; e.ln = '1; e.lv = 4'd15;
    end else begin
      p = b_d2; mm = m_d2;
      b_d2 = b_d1; b_d1 = (btn == 1'b0);
      m_d2 = m_d1; m_d1 = mode;
      on = ((cyc / SLOT) % 15) < lvl;
      e.lp = on ? pattern : '0;
      e.ln = ~e.lp;
      pulse = 0;
      if (p != db) begin
        dbrun++;
        if (dbrun == DB) begin db = p; dbrun = 0; pulse = p; end
      end else dbrun = 0;
      if (!breathe) begin
        if (mm) begin breathe = 1; going_up = 1; fcnt = 0; end
        else if (pulse) lvl = (lvl + 1) % 16;
      end else if (!mm) begin
        breathe = 0; fcnt = 0;
      end else begin
        fcnt++;
        if (fcnt == FADE) begin
          fcnt = 0;
          if (going_up) begin
            if (lvl >= 14) begin lvl = 15; going_up = 0; end
            else lvl++;
          end else begin
            if (lvl == 1) begin lvl = 0; going_up = 1; end
            else lvl--;
          end
        end
      end
      cyc++;
      e.lv = 4'(lvl);
    end
    sb.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks += 3;
      if (led_p !== e.lp) begin
        failures++;
        $display("FAIL led_pos got=%h want=%h t=%0t", led_p, e.lp, $time);
      end
      if (led_n !== e.ln) begin
        failures++;
        $display("FAIL led_neg got=%h want=%h t=%0t", led_n, e.ln, $time);
      end
      if (lvl_p !== e.lv || lvl_n !== e.lv) begin
        failures++;
        $display("FAIL level got=%0d/%0d want=%0d t=%0t", lvl_p, lvl_n, e.lv, $time);
      end
    end
  end

  task automatic cyc_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int hold, input int rel);
    btn = 1'b0; cyc_n(hold);
    btn = 1'b1; cyc_n(rel);
  endtask

  initial begin
    cyc_n(3);
    rstn = 1'b1;
    cyc_n(1000);
    press(2 * DB, 2 * DB);
    cyc_n(1000);
    press(2 * DB, 2 * DB);
    cyc_n(2000);
    // short glitch, then a bounce train ending in a long hold and a bouncy release
    btn = 1'b0; cyc_n(DB - 2);
    btn = 1'b1; cyc_n(50);
    repeat (6) begin
      btn = 1'b0; cyc_n($urandom_range(5, DB / 3));
      btn = 1'b1; cyc_n($urandom_range(5, DB / 3));
    end
    btn = 1'b0; cyc_n(2 * DB);
    repeat (4) begin
      btn = 1'b1; cyc_n($urandom_range(5, DB / 3));
      btn = 1'b0; cyc_n($urandom_range(5, DB / 3));
    end
    btn = 1'b1; cyc_n(2 * DB);
    repeat (300) begin
      pattern = W'($urandom);
      cyc_n($urandom_range(1, 20));
    end
    repeat (3) press(DB + $urandom_range(10, 200), DB + $urandom_range(10, 200));
    // breathe sweep with presses that must be ignored
    mode = 1'b1;
    repeat (8) press(DB + $urandom_range(10, 200), DB + $urandom_range(10, 200));
    cyc_n(5000 + $urandom_range(0, 999));
    mode = 1'b0;
    cyc_n(3000);
    // press pulse lands on the same edge as the MANUAL->UP transition
    btn = 1'b0; cyc_n(DB - 1);
    mode = 1'b1; cyc_n(DB + 100);
    btn = 1'b1; cyc_n(2 * DB);
    pattern = 8'h0F;
    cyc_n(3000 + $urandom_range(0, 500));
    rstn = 1'b0; cyc_n(1);
    rstn = 1'b1; mode = 1'b0;
    cyc_n(2000);
    repeat (200) begin
      pattern = W'($urandom);
      cyc_n($urandom_range(1, 10));
    end
    cyc_n(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
